// File: rtl/freq_report_ctrl.sv
// Command/report sequencer: decodes host commands, snapshots {high_cnt,low_cnt} and drives the TX handshake.
// Define FREQ_REPORT_CHECKSUM_EN to append a {seq, 8'h00, xor8, 8'hC5} checksum word to every report.
module freq_report_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] CMD_SINGLE     = 32'hFFFFA5A5,
    parameter logic [DATA_WIDTH-1:0] CMD_STREAM_ON  = 32'hFFFF5A01,
    parameter logic [DATA_WIDTH-1:0] CMD_STREAM_OFF = 32'hFFFF5A00,
    parameter int                    REPORT_PERIOD  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic [15:0]           high_cnt,
    input  logic [15:0]           low_cnt,
    input  logic                  tx_done,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  send_en,
    output logic                  streaming,
    output logic                  overrun
);

    localparam int CW = $clog2(REPORT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(REPORT_PERIOD - 1);

`ifdef FREQ_REPORT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SEND, S_WAIT, S_CHK, S_CHK_SEND, S_CHK_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SEND, S_WAIT
    } state_t;
`endif

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    streaming_reg, streaming_next;
    logic                    pending_reg, pending_next;
    logic                    overrun_reg, overrun_next;
    logic                    cmd_single, cmd_on, cmd_off, wrap, request;
`ifdef FREQ_REPORT_CHECKSUM_EN
    logic [7:0]              seq_reg, seq_next;
    logic [7:0]              xor8;
`endif

    assign cmd_single = rx_done && (rx_data == CMD_SINGLE);
    assign cmd_on     = rx_done && (rx_data == CMD_STREAM_ON);
    assign cmd_off    = rx_done && (rx_data == CMD_STREAM_OFF);
    // A stream command in the same cycle overrides the wrap, so only one request is raised.
    assign wrap       = streaming_reg && (cnt_reg == CNT_LAST) && !cmd_on && !cmd_off;
    assign request    = cmd_single || cmd_on || wrap;

    always_comb begin
        cnt_next       = cnt_reg;
        streaming_next = streaming_reg;
        if (cmd_on) begin
            cnt_next       = '0;
            streaming_next = 1'b1;
        end else if (cmd_off) begin
            cnt_next       = '0;
            streaming_next = 1'b0;
        end else if (streaming_reg) begin
            cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    always_comb begin
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        if (cmd_off) begin
            pending_next = 1'b0;
            overrun_next = 1'b0;
        end else if (state_reg == S_IDLE) begin
            // Leaving IDLE consumes the queued request; a fresh one in the same cycle takes its slot.
            pending_next = pending_reg && request;
        end else if (request) begin
            if (pending_reg) overrun_next = 1'b1;
            else             pending_next = 1'b1;
        end
    end

`ifdef FREQ_REPORT_CHECKSUM_EN
    assign xor8 = tx_data_reg[31:24] ^ tx_data_reg[23:16] ^ tx_data_reg[15:8] ^ tx_data_reg[7:0];
`endif

    always_comb begin
        state_next   = state_reg;
        tx_data_next = tx_data_reg;
`ifdef FREQ_REPORT_CHECKSUM_EN
        seq_next     = seq_reg;
`endif
        case (state_reg)
            S_IDLE:  if (request || pending_reg) state_next = S_LATCH;
            S_LATCH: begin
                tx_data_next = {high_cnt, low_cnt};
                state_next   = S_SEND;
            end
            S_SEND:  state_next = S_WAIT;
`ifdef FREQ_REPORT_CHECKSUM_EN
            S_WAIT:  if (tx_done) state_next = S_CHK;
            S_CHK: begin
                tx_data_next = {seq_reg, 8'h00, xor8, 8'hC5};
                seq_next     = seq_reg + 8'd1;
                state_next   = S_CHK_SEND;
            end
            S_CHK_SEND: state_next = S_CHK_WAIT;
            S_CHK_WAIT: if (tx_done) state_next = S_IDLE;
`else
            S_WAIT:  if (tx_done) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            tx_data_reg   <= '0;
            cnt_reg       <= '0;
            streaming_reg <= 1'b0;
            pending_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef FREQ_REPORT_CHECKSUM_EN
            seq_reg       <= 8'd0;
`endif
        end else begin
            state_reg     <= state_next;
            tx_data_reg   <= tx_data_next;
            cnt_reg       <= cnt_next;
            streaming_reg <= streaming_next;
            pending_reg   <= pending_next;
            overrun_reg   <= overrun_next;
`ifdef FREQ_REPORT_CHECKSUM_EN
            seq_reg       <= seq_next;
`endif
        end
    end

`ifdef FREQ_REPORT_CHECKSUM_EN
    assign send_en   = (state_reg == S_SEND) || (state_reg == S_CHK_SEND);
`else
    assign send_en   = (state_reg == S_SEND);
`endif
    assign tx_data   = tx_data_reg;
    assign streaming = streaming_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_freq_report_ctrl.sv
// Bench for freq_report_ctrl (default build): edge-schedule reference model plus directed scenarios.
module tb_freq_report_ctrl;

    localparam int P = 100;
    localparam logic [31:0] C_SINGLE = 32'hFFFFA5A5;
    localparam logic [31:0] C_ON     = 32'hFFFF5A01;
    localparam logic [31:0] C_OFF    = 32'hFFFF5A00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_done = 1'b0;
    logic [15:0] high_cnt = '0;
    logic [15:0] low_cnt = '0;
    logic        tx_done = 1'b0;
    logic [31:0] tx_data;
    logic        send_en;
    logic        streaming;
    logic        overrun;

    int n_pass = 0;
    int n_total = 0;
    int edge_cnt = 0;
    int last_rx_cyc = 0;

    freq_report_ctrl #(.REPORT_PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .tx_done(tx_done),
        .tx_data(tx_data), .send_en(send_en), .streaming(streaming), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a report started at sampling edge s sends right after edge s+1 with the
    // counts sampled at s+1, and is busy until a tx_done sampled at or after edge s+3.
    int          m_busy = 0, m_s = 0, m_pend = 0, m_ovr = 0, m_str = 0, m_s0 = 0;
    logic [31:0] m_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_pend = 0; m_ovr = 0; m_str = 0; m_data = '0;
            end
            check("model_send_en", {31'd0, send_en}, {31'd0, (m_busy != 0) && (edge_cnt == m_s + 1)});
            check("model_tx_data", tx_data, m_data);
            check("model_streaming", {31'd0, streaming}, m_str);
            check("model_overrun", {31'd0, overrun}, m_ovr);
            if (rst_n) begin
                int  u;
                bit  single, on, off, wrap, req, done_ok;
                u       = edge_cnt + 1;
                single  = rx_done && rx_data == C_SINGLE;
                on      = rx_done && rx_data == C_ON;
                off     = rx_done && rx_data == C_OFF;
                wrap    = (m_str != 0) && !on && !off && (u > m_s0) && ((u - m_s0) % P == 0);
                req     = single || on || wrap;
                done_ok = (m_busy != 0) && tx_done && (u >= m_s + 3);
                if (m_busy != 0 && u == m_s + 1) m_data = {high_cnt, low_cnt};
                if (m_busy == 0) begin
                    if (req || m_pend != 0) begin
                        m_busy = 1;
                        m_s    = u;
                        m_pend = (m_pend != 0 && req) ? 1 : 0;
                    end
                end else if (req) begin
                    if (m_pend != 0) m_ovr = 1;
                    else             m_pend = 1;
                end
                if (off) begin m_pend = 0; m_ovr = 0; m_str = 0; end
                if (on)  begin m_str = 1; m_s0 = u; end
                if (done_ok) m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [31:0] d);
        rx_data = d;
        rx_done = 1'b1;
        last_rx_cyc = edge_cnt;
        tick();
        rx_done = 1'b0;
        rx_data = '0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_send(output int cyc);
        cyc = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (send_en) begin cyc = edge_cnt; break; end
        end
        if (cyc < 0) begin
            n_total++;
            $display("FAIL wait_send: no send_en within 300 cycles, required one");
        end
    endtask

    task automatic count_sends(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (send_en) cnt++;
        end
    endtask

    initial begin
        int c0, c1, c2, cnt, s0, guard;
        // Reset state
        repeat (3) tick();
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_send_en", {31'd0, send_en}, 32'd0);
        check("rst_streaming", {31'd0, streaming}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single report: latency two cycles, data held until tx_done
        high_cnt = 16'h1234; low_cnt = 16'h0056;
        pulse_rx(C_SINGLE);
        wait_send(c0);
        check("single_latency", c0 - last_rx_cyc, 32'd2);
        check("single_data", tx_data, 32'h12340056);
        high_cnt = 16'hBEEF; low_cnt = 16'hCAFE;
        repeat (19) tick();
        check("single_hold", tx_data, 32'h12340056);
        pulse_tx_done();
        $display("single report: tx_data=%h latency=%0d", 32'h12340056, c0 - last_rx_cyc);

        // Unknown command ignored, stray tx_done in IDLE ignored
        pulse_rx(32'h00000001);
        pulse_tx_done();
        count_sends(10, cnt);
        check("ignored_cmd_sends", cnt, 32'd0);
        check("ignored_cmd_streaming", {31'd0, streaming}, 32'd0);
        $display("unknown command: sends=%0d", cnt);

        // Streaming: first report at N+2, then every P cycles
        high_cnt = 16'h0001; low_cnt = 16'h0002;
        pulse_rx(C_ON);
        wait_send(c0);
        check("stream_first_latency", c0 - last_rx_cyc, 32'd2);
        check("stream_on", {31'd0, streaming}, 32'd1);
        repeat (19) tick();
        pulse_tx_done();
        high_cnt = 16'h0A0B;
        wait_send(c1);
        check("stream_period1", c1 - c0, P);
        repeat (19) tick();
        pulse_tx_done();
        low_cnt = 16'hFFFF;
        wait_send(c2);
        check("stream_period2", c2 - c1, P);
        check("stream_data3", tx_data, 32'h0A0BFFFF);
        repeat (19) tick();
        pulse_tx_done();
        pulse_rx(C_OFF);
        check("stream_off", {31'd0, streaming}, 32'd0);
        count_sends(250, cnt);
        check("stream_off_sends", cnt, 32'd0);
        $display("streaming: periods=%0d,%0d sends_after_off=%0d", c1 - c0, c2 - c1, cnt);

        // Queue depth 1, overrun, and clearing by STREAM_OFF
        high_cnt = 16'h5555; low_cnt = 16'h6666;
        pulse_rx(C_SINGLE);
        wait_send(c0);
        repeat (3) tick();
        pulse_rx(C_SINGLE);
        check("queue_no_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) tick();
        pulse_rx(C_SINGLE);
        check("queue_overrun", {31'd0, overrun}, 32'd1);
        repeat (5) tick();
        pulse_tx_done();
        count_sends(10, cnt);
        check("queue_extra_reports", cnt, 32'd1);
        pulse_tx_done();
        count_sends(10, cnt);
        check("queue_no_more", cnt, 32'd0);
        pulse_rx(C_OFF);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        $display("queue: overrun set then cleared, extra reports=1");

        // Reset during WAIT
        pulse_rx(C_SINGLE);
        wait_send(c0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_tx_data", tx_data, 32'h0);
        check("midrst_send_en", {31'd0, send_en}, 32'd0);
        check("midrst_streaming", {31'd0, streaming}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_tx_done();
        count_sends(20, cnt);
        check("midrst_no_send", cnt, 32'd0);
        $display("reset mid-transfer: sends afterwards=%0d", cnt);

        // SINGLE coinciding with the period wrap gives one report only
        pulse_rx(C_ON);
        s0 = last_rx_cyc + 1;
        wait_send(c0);
        repeat (19) tick();
        pulse_tx_done();
        guard = 0;
        while (edge_cnt < s0 + P - 1 && guard < 500) begin tick(); guard++; end
        pulse_rx(C_SINGLE);
        count_sends(60, cnt);
        check("coincident_one_report", cnt, 32'd1);
        check("coincident_no_overrun", {31'd0, overrun}, 32'd0);
        pulse_tx_done();
        pulse_rx(C_OFF);
        repeat (5) tick();
        $display("coincident request: reports=%0d", cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
